// File: rtl/dmem_pkg.sv
// Shared definitions for the dmem responder: FSM state encoding, word size, wait counter width.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dmem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } dmem_state_t;

  localparam int WORD_BYTES = 4;
  // Wait-state counter width; covers the legal WAIT_CYCLES range 0..15.
  localparam int CNT_W      = 4;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage with a synchronous write port and a registered read port.
// Latency: write lands and read data appears at the same clock edge as the enable.
// Backpressure: none; one access per enabled edge.
// Ports: clk, rst (clears only the read register), wr_en/rd_en, idx (word index),
//        wdata (write word), rdata (registered read word, holds until next rd_en).
module dmem_array #(
  parameter int WIDTH    = 32,
  parameter int ADDRBITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic                rd_en,
  input  logic [ADDRBITS-1:0] idx,
  input  logic [WIDTH-1:0]    wdata,
  output logic [WIDTH-1:0]    rdata
);

  // Storage contents are intentionally not reset.
  logic [WIDTH-1:0] mem [2**ADDRBITS];

  always_ff @(posedge clk) begin
    if (wr_en) mem[idx] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rdata <= '0;
    else if (rd_en) rdata <= mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder: captures a word request, inserts WAIT_CYCLES wait states, then commits.
// Latency: ready pulses WAIT_CYCLES+1 cycles after the acceptance cycle; spacing WAIT_CYCLES+2.
// Backpressure: req is sampled only in IDLE; the requester holds or re-issues until accepted.
// Ports: clk, reset (async active-high), req/we/adr/writedata (request), ready (1-cycle done),
//        memdata (last read word, held), err (misalignment flag, valid with ready).
// Optional feature: define DMEM_MISALIGN_CHECK_EN to reject accesses with adr[1:0] != 0.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int ADDRBITS    = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             we,
  input  logic [WIDTH-1:0] adr,
  input  logic [WIDTH-1:0] writedata,
  output logic             ready,
  output logic [WIDTH-1:0] memdata,
  output logic             err
);

  localparam bit NO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [CNT_W-1:0] CNT_INIT = NO_WAIT ? '0 : CNT_W'(WAIT_CYCLES - 1);

  dmem_state_t         state;
  logic [CNT_W-1:0]    cnt;
  logic                cap_we;
  logic [ADDRBITS-1:0] cap_idx;
  logic [WIDTH-1:0]    cap_wdata;

  // With zero wait states the commit happens on the acceptance edge itself,
  // so the live request fields must be used instead of the captured copies.
  logic                in_idle;
  logic                acc_we;
  logic [ADDRBITS-1:0] acc_idx;
  logic [WIDTH-1:0]    acc_wdata;
  logic                commit;
  logic                misalign;

  assign in_idle   = (state == S_IDLE);
  assign acc_we    = in_idle ? we                   : cap_we;
  assign acc_idx   = in_idle ? adr[ADDRBITS+1:2]    : cap_idx;
  assign acc_wdata = in_idle ? writedata            : cap_wdata;
  assign commit    = (in_idle && req && NO_WAIT) || (state == S_WAIT && cnt == '0);

`ifdef DMEM_MISALIGN_CHECK_EN
  logic [$clog2(WORD_BYTES)-1:0] cap_lo;
  logic [$clog2(WORD_BYTES)-1:0] acc_lo;
  logic                          err_q;
  logic                          unused_adr;

  assign acc_lo     = in_idle ? adr[1:0] : cap_lo;
  assign misalign   = (acc_lo != '0);
  assign err        = err_q;
  assign unused_adr = ^adr[WIDTH-1:ADDRBITS+2];
`else
  logic unused_adr;

  assign misalign   = 1'b0;
  assign err        = 1'b0;
  // Byte offset and high address bits play no part in addressing; words wrap.
  assign unused_adr = ^{adr[WIDTH-1:ADDRBITS+2], adr[1:0]};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ready     <= 1'b0;
      cap_we    <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= '0;
`ifdef DMEM_MISALIGN_CHECK_EN
      cap_lo    <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            cap_we    <= we;
            cap_idx   <= adr[ADDRBITS+1:2];
            cap_wdata <= writedata;
`ifdef DMEM_MISALIGN_CHECK_EN
            cap_lo    <= adr[1:0];
`endif
            if (NO_WAIT) begin
              state <= S_RESP;
              ready <= 1'b1;
`ifdef DMEM_MISALIGN_CHECK_EN
              err_q <= misalign;
`endif
            end else begin
              state <= S_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            state <= S_RESP;
            ready <= 1'b1;
`ifdef DMEM_MISALIGN_CHECK_EN
            err_q <= misalign;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
          ready <= 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
          err_q <= 1'b0;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Writes leave memdata untouched because only reads enable the read register.
  dmem_array #(
    .WIDTH    (WIDTH),
    .ADDRBITS (ADDRBITS)
  ) u_array (
    .clk   (clk),
    .rst   (reset),
    .wr_en (commit && acc_we && !misalign),
    .rd_en (commit && !acc_we && !misalign),
    .idx   (acc_idx),
    .wdata (acc_wdata),
    .rdata (memdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states, one with none.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req2 = 1'b0;
  logic        req0 = 1'b0;
  logic        we = 1'b0;
  logic [31:0] adr = '0;
  logic [31:0] writedata = '0;
  logic        ready2, err2, ready0, err0;
  logic [31:0] memdata2, memdata0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_responder #(.WIDTH(32), .ADDRBITS(8), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .req(req2), .we(we), .adr(adr), .writedata(writedata),
    .ready(ready2), .memdata(memdata2), .err(err2)
  );

  dmem_responder #(.WIDTH(32), .ADDRBITS(8), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we), .adr(adr), .writedata(writedata),
    .ready(ready0), .memdata(memdata0), .err(err0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issues one request on the selected instance (sel=1 -> zero-wait instance),
  // scribbles the request fields after acceptance, and checks the ready pulse.
  task automatic txn(input string tag, input bit sel, input bit w, input logic [31:0] a,
                     input logic [31:0] d, input int exp_lat, input bit exp_err,
                     input bit chk_rd, input logic [31:0] exp_rd);
    int lat;
    we = w; adr = a; writedata = d;
    if (sel) req0 = 1'b1; else req2 = 1'b1;
    @(posedge clk); #1;
    req0 = 1'b0; req2 = 1'b0;
    we = ~w; adr = 32'hFFFF_FFFC; writedata = 32'h0BAD_0BAD;
    lat = 1;
    while (!(sel ? ready0 : ready2) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_err"}, sel ? err0 : err2, {31'd0, exp_err});
    if (chk_rd) chk({tag, "_data"}, sel ? memdata0 : memdata2, exp_rd);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, sel ? ready0 : ready2, 0);
  endtask

  initial begin
    int pulses, pos1, pos2, n;
    bit prev, dbl, seen;

    // Power-on reset
    #12;
    chk("rst_ready", ready2, 0);
    chk("rst_err", err2, 0);
    chk("rst_memdata", memdata2, 0);
    chk("rst_memdata0", memdata0, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Write then read back, 3-cycle latency each
    txn("wr10", 0, 1, 32'h10, 32'hDEADBEEF, 3, 0, 0, 0);
    txn("rd10", 0, 0, 32'h10, 0, 3, 0, 1, 32'hDEADBEEF);

    // Writes leave memdata untouched
    txn("wr30", 0, 1, 32'h30, 32'h11111111, 3, 0, 1, 32'hDEADBEEF);

    // Address wrap modulo 256 words
    txn("wr400", 0, 1, 32'h400, 32'h12345678, 3, 0, 0, 0);
    txn("rd000", 0, 0, 32'h000, 0, 3, 0, 1, 32'h12345678);
    txn("rd30", 0, 0, 32'h30, 0, 3, 0, 1, 32'h11111111);

    // Back-to-back: req held high; accepts every 4 cycles
    we = 1'b0; adr = 32'h10; req2 = 1'b1;
    pulses = 0; pos1 = 0; pos2 = 0; prev = 1'b0; dbl = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (ready2) begin
        pulses++;
        if (prev) dbl = 1'b1;
        if (pulses == 1) pos1 = i;
        if (pulses == 2) pos2 = i;
      end
      prev = ready2;
    end
    req2 = 1'b0;
    chk("b2b_pulses", pulses, 3);
    chk("b2b_pos1", pos1, 3);
    chk("b2b_pos2", pos2, 7);
    chk("b2b_double", {31'd0, dbl}, 0);
    chk("b2b_data", memdata2, 32'hDEADBEEF);
    @(posedge clk); #1;

    // Asynchronous mid-run reset
    reset = 1'b1;
    #1;
    chk("arst_ready", ready2, 0);
    chk("arst_err", err2, 0);
    chk("arst_memdata", memdata2, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Reset during WAIT aborts the write
    txn("wr20", 0, 1, 32'h20, 32'h0BADF00D, 3, 0, 0, 0);
    we = 1'b1; adr = 32'h20; writedata = 32'hA5A5A5A5; req2 = 1'b1;
    @(posedge clk); #1;
    req2 = 1'b0;
    reset = 1'b1;
    seen = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      seen |= ready2;
    end
    reset = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      seen |= ready2;
    end
    chk("wait_rst_no_ready", {31'd0, seen}, 0);
    txn("rd20_abort", 0, 0, 32'h20, 0, 3, 0, 1, 32'h0BADF00D);

    // Reset during RESP clears ready; committed write remains
    we = 1'b1; adr = 32'h40; writedata = 32'h77777777; req2 = 1'b1;
    @(posedge clk); #1;
    req2 = 1'b0;
    n = 1;
    while (!ready2 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("resp_rst_lat", n, 3);
    reset = 1'b1;
    #1;
    chk("resp_rst_ready", ready2, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    txn("rd40", 0, 0, 32'h40, 0, 3, 0, 1, 32'h77777777);

    // Misaligned write to 0x22
`ifdef DMEM_MISALIGN_CHECK_EN
    txn("wr22", 0, 1, 32'h22, 32'hCAFEF00D, 3, 1, 0, 0);
    txn("rd20_mis", 0, 0, 32'h20, 0, 3, 0, 1, 32'h0BADF00D);
`else
    txn("wr22", 0, 1, 32'h22, 32'hCAFEF00D, 3, 0, 0, 0);
    txn("rd20_mis", 0, 0, 32'h20, 0, 3, 0, 1, 32'hCAFEF00D);
`endif

    // Zero wait states: ready in the cycle right after acceptance
    txn("z_wr8", 1, 1, 32'h8, 32'h00000055, 1, 0, 0, 0);
    txn("z_rd8", 1, 0, 32'h8, 0, 1, 0, 1, 32'h00000055);
    txn("z_wr408", 1, 1, 32'h408, 32'h0000AAAA, 1, 0, 0, 0);
    txn("z_rd8b", 1, 0, 32'h8, 0, 1, 0, 1, 32'h0000AAAA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
